mips_multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS datapath. It sequences the shared ALU, register file and the unified instruction/data memory port across fetch, decode, execute, memory and writeback steps. It replaces the per-instruction combinational CONTROL decode with a state-driven control-signal generator. It includes a memory-ready handshake, a wait-timeout watchdog and error trapping.

---
 rtl/mips_multicycle_ctrl.sv | 128 ++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS control FSM with memory handshake, wait watchdog and trap.
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.
module mips_multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
`ifdef MC_PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
`endif
  output logic [3:0]       state,
  output logic             err
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB,
    BRANCH, JUMP, ADDI_EX, ADDI_WB, TRAP
  } state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tmo, wait_st;
  // The branch decision is made in the datapath (pc_write_cond & zero).
  logic unused_zero;
  assign unused_zero = zero;
  assign wait_st = state_q inside {FETCH, MEM_RD, MEM_WR};
  assign tmo = !mem_ready && cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = TRAP;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : tmo ? TRAP : FETCH;
      DECODE:   state_d = opcode == 6'b000000 ? R_EX :
                          (opcode == 6'b100011 || opcode == 6'b101011) ? MEM_ADDR :
                          opcode == 6'b000100 ? BRANCH :
                          opcode == 6'b000010 ? JUMP :
                          opcode == 6'b001000 ? ADDI_EX : TRAP;
      MEM_ADDR: state_d = opcode == 6'b101011 ? MEM_WR : MEM_RD;
      MEM_RD:   state_d = mem_ready ? MEM_WB : tmo ? TRAP : MEM_RD;
      MEM_WR:   state_d = mem_ready ? FETCH : tmo ? TRAP : MEM_WR;
      R_EX:     state_d = R_WB;
      ADDI_EX:  state_d = ADDI_WB;
      MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: state_d = FETCH;
      default:  state_d = TRAP;
    endcase
    cnt_d = (wait_st && !mem_ready && state_d == state_q) ? cnt_q + 1'b1 : '0;
  end
  always_comb begin
    {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write} = '0;
    {mem_to_reg, reg_dst, reg_write, alu_src_a} = '0;
    {alu_src_b, alu_op, pc_source} = '0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_read = 1'b1;
          alu_src_b = 2'b01;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        DECODE: alu_src_b = 2'b11;
        MEM_ADDR, ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_RD: {mem_read, i_or_d} = 2'b11;
        MEM_WB: {reg_write, mem_to_reg} = 2'b11;
        MEM_WR: {mem_write, i_or_d} = 2'b11;
        R_EX: begin
          alu_src_a = 1'b1;
          alu_op = 2'b10;
        end
        R_WB: {reg_write, reg_dst} = 2'b11;
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op = 2'b01;
          pc_write_cond = 1'b1;
          pc_source = 2'b01;
        end
        JUMP: begin
          pc_write = 1'b1;
          pc_source = 2'b10;
        end
        ADDI_WB: reg_write = 1'b1;
        default: ;
      endcase
    end
  end
  assign state = state_q;
  assign err = !rst && state_q == TRAP;
`ifdef MC_PERF_CNT_EN
  logic instr_done;
  assign instr_done = state_d == FETCH &&
                      state_q inside {MEM_WB, R_WB, ADDI_WB, MEM_WR, BRANCH, JUMP};
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      cnt_q <= '0;
`ifdef MC_PERF_CNT_EN
      cycle_cnt <= '0;
      instr_cnt <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
`ifdef MC_PERF_CNT_EN
      if (state_q != TRAP) cycle_cnt <= cycle_cnt + 1'b1;
      if (instr_done) instr_cnt <= instr_cnt + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed self-checking bench for mips_multicycle_ctrl.
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'b000000;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, err;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [15:0] ctl;
  int checks = 0, failures = 0;
  mips_multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .err(err)
  );
  always #5 clk = ~clk;
  // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_dst,reg_write,alu_src_a,alu_src_b,alu_op,pc_source}
  assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  localparam logic [15:0] C_FETCH_RDY = 16'h9410, C_FETCH_WAIT = 16'h1010,
    C_DECODE = 16'h0030, C_MEM_ADDR = 16'h0060, C_MEM_RD = 16'h3000,
    C_MEM_WB = 16'h0280, C_MEM_WR = 16'h2800, C_R_EX = 16'h0048, C_R_WB = 16'h0180,
    C_BRANCH = 16'h4045, C_JUMP = 16'h8002, C_ADDI_EX = 16'h0060, C_ADDI_WB = 16'h0080;
  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic expect_st(input string tag, input logic [3:0] st, input logic [15:0] c, input logic e);
    #1;
    checks++;
    assert (state === st && ctl === c && err === e)
      else begin
        failures++;
        $error("FAIL %s: state=%0d ctl=%h err=%b, expected state=%0d ctl=%h err=%b",
               tag, state, ctl, err, st, c, e);
      end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_st("reset_hold", 4'd0, 16'h0000, 1'b0);
    rst = 1'b0;
    expect_st("fetch_after_reset", 4'd0, C_FETCH_RDY, 1'b0);
    adv(); expect_st("r_decode", 4'd1, C_DECODE, 1'b0);
    adv(); expect_st("r_ex", 4'd6, C_R_EX, 1'b0);
    adv(); expect_st("r_wb", 4'd7, C_R_WB, 1'b0);
    adv(); expect_st("r_fetch", 4'd0, C_FETCH_RDY, 1'b0);
    opcode = 6'b100011;
    adv(); expect_st("lw_decode", 4'd1, C_DECODE, 1'b0);
    adv(); expect_st("lw_addr", 4'd2, C_MEM_ADDR, 1'b0);
    adv(); mem_ready = 1'b0; expect_st("lw_rd_wait1", 4'd3, C_MEM_RD, 1'b0);
    adv(); expect_st("lw_rd_wait2", 4'd3, C_MEM_RD, 1'b0);
    adv(); mem_ready = 1'b1; expect_st("lw_rd_ready", 4'd3, C_MEM_RD, 1'b0);
    adv(); expect_st("lw_wb", 4'd4, C_MEM_WB, 1'b0);
    adv(); expect_st("lw_fetch", 4'd0, C_FETCH_RDY, 1'b0);
    opcode = 6'b101011;
    adv(); expect_st("sw_decode", 4'd1, C_DECODE, 1'b0);
    adv(); expect_st("sw_addr", 4'd2, C_MEM_ADDR, 1'b0);
    adv(); expect_st("sw_wr", 4'd5, C_MEM_WR, 1'b0);
    adv(); expect_st("sw_fetch", 4'd0, C_FETCH_RDY, 1'b0);
    opcode = 6'b000100; zero = 1'b1;
    adv(); expect_st("beq_decode", 4'd1, C_DECODE, 1'b0);
    adv(); expect_st("beq_branch", 4'd8, C_BRANCH, 1'b0);
    adv(); expect_st("beq_fetch", 4'd0, C_FETCH_RDY, 1'b0);
    opcode = 6'b000010; zero = 1'b0;
    adv(); expect_st("j_decode", 4'd1, C_DECODE, 1'b0);
    adv(); expect_st("j_jump", 4'd9, C_JUMP, 1'b0);
    adv(); expect_st("j_fetch", 4'd0, C_FETCH_RDY, 1'b0);
    opcode = 6'b001000;
    adv(); expect_st("addi_decode", 4'd1, C_DECODE, 1'b0);
    adv(); expect_st("addi_ex", 4'd10, C_ADDI_EX, 1'b0);
    adv(); expect_st("addi_wb", 4'd11, C_ADDI_WB, 1'b0);
    adv(); expect_st("addi_fetch", 4'd0, C_FETCH_RDY, 1'b0);
    opcode = 6'b000000; mem_ready = 1'b0;
    expect_st("fetch_wait_c1", 4'd0, C_FETCH_WAIT, 1'b0);
    for (int i = 2; i <= 16; i++) begin
      adv();
      if (i == 16) mem_ready = 1'b1;
      expect_st($sformatf("fetch_wait_c%0d", i), 4'd0, i == 16 ? C_FETCH_RDY : C_FETCH_WAIT, 1'b0);
    end
    adv(); expect_st("late_ready_decode", 4'd1, C_DECODE, 1'b0);
    adv(); expect_st("late_ready_ex", 4'd6, C_R_EX, 1'b0);
    adv(); expect_st("late_ready_wb", 4'd7, C_R_WB, 1'b0);
    adv(); mem_ready = 1'b0;
    expect_st("tmo_c1", 4'd0, C_FETCH_WAIT, 1'b0);
    for (int i = 2; i <= 16; i++) begin
      adv();
      expect_st($sformatf("tmo_c%0d", i), 4'd0, C_FETCH_WAIT, 1'b0);
    end
    adv(); expect_st("tmo_trap", 4'd12, 16'h0000, 1'b1);
    mem_ready = 1'b1;
    adv(); expect_st("tmo_trap_sticky", 4'd12, 16'h0000, 1'b1);
    rst = 1'b1;
    expect_st("trap_rst", 4'd0, 16'h0000, 1'b0);
    adv(); rst = 1'b0;
    expect_st("trap_rst_release", 4'd0, C_FETCH_RDY, 1'b0);
    opcode = 6'b111111;
    adv(); expect_st("ill_decode", 4'd1, C_DECODE, 1'b0);
    for (int i = 0; i < 20; i++) begin
      adv();
      expect_st($sformatf("ill_trap_%0d", i), 4'd12, 16'h0000, 1'b1);
    end
    rst = 1'b1;
    expect_st("ill_rst", 4'd0, 16'h0000, 1'b0);
    adv(); rst = 1'b0; opcode = 6'b100011;
    adv(); expect_st("mid_decode", 4'd1, C_DECODE, 1'b0);
    adv(); expect_st("mid_addr", 4'd2, C_MEM_ADDR, 1'b0);
    adv(); expect_st("mid_rd", 4'd3, C_MEM_RD, 1'b0);
    rst = 1'b1;
    expect_st("mid_rst_async", 4'd0, 16'h0000, 1'b0);
    adv(); expect_st("mid_rst_hold", 4'd0, 16'h0000, 1'b0);
    rst = 1'b0;
    expect_st("mid_rst_fetch", 4'd0, C_FETCH_RDY, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
